// File: rtl/serial_right_loader.sv
// rtl/serial_right_loader.sv - LSB-first parallel-to-serial loader feeding serial_right
// Optional even-parity trailer bit: define SERIAL_RIGHT_LOADER_PARITY_EN.
module serial_right_loader #(
    parameter int   WIDTH      = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             out,
    output logic             out_valid,
    output logic             last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

`ifdef SERIAL_RIGHT_LOADER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
    logic par;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    count;
    logic             final_bit;
    logic             accept;

    // final_bit marks the cycle whose bit closes the frame; a new word may load then
    always_comb begin
        final_bit  = 1'b0;
`ifdef SERIAL_RIGHT_LOADER_PARITY_EN
        final_bit  = (state == PARITY);
`else
        final_bit  = (state == SHIFT) && (count == CW'(WIDTH - 1));
`endif
        load_ready = rst && ((state == IDLE) || final_bit);
        accept     = load_valid && load_ready;
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) state_next = SHIFT;
            end
            SHIFT: begin
`ifdef SERIAL_RIGHT_LOADER_PARITY_EN
                if (count == CW'(WIDTH - 1)) state_next = PARITY;
`else
                if (final_bit) state_next = accept ? SHIFT : IDLE;
`endif
            end
`ifdef SERIAL_RIGHT_LOADER_PARITY_EN
            PARITY: begin
                state_next = accept ? SHIFT : IDLE;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            sr        <= '0;
            count     <= '0;
            out       <= IDLE_LEVEL;
            out_valid <= 1'b0;
            last      <= 1'b0;
            busy      <= 1'b0;
`ifdef SERIAL_RIGHT_LOADER_PARITY_EN
            par       <= 1'b0;
`endif
        end else begin
            state <= state_next;
            if (accept) begin
                sr        <= load_data;
                count     <= '0;
                out       <= load_data[0];
                out_valid <= 1'b1;
                last      <= 1'b0;
                busy      <= 1'b1;
`ifdef SERIAL_RIGHT_LOADER_PARITY_EN
                par       <= ^load_data;
`endif
            end else if (state_next == IDLE) begin
                sr        <= '0;
                count     <= '0;
                out       <= IDLE_LEVEL;
                out_valid <= 1'b0;
                last      <= 1'b0;
                busy      <= 1'b0;
`ifdef SERIAL_RIGHT_LOADER_PARITY_EN
            end else if (state_next == PARITY) begin
                out  <= par;
                last <= 1'b1;
`endif
            end else if (state == SHIFT) begin
                sr    <= sr >> 1;
                out   <= sr[1];
                count <= count + CW'(1);
`ifdef SERIAL_RIGHT_LOADER_PARITY_EN
                last  <= 1'b0;
`else
                last  <= (count == CW'(WIDTH - 2));
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_right_loader.sv
// tb/tb_serial_right_loader.sv - directed self-checking bench for serial_right_loader
module tb_serial_right_loader;

    localparam int W = 8;
`ifdef SERIAL_RIGHT_LOADER_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         load_valid;
    logic [W-1:0] load_data;
    logic         load_ready;
    logic         out;
    logic         out_valid;
    logic         last;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    serial_right_loader #(.WIDTH(W), .IDLE_LEVEL(1'b0)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .out        (out),
        .out_valid  (out_valid),
        .last       (last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference bit idx of a frame: data bits LSB first, then the even-parity bit
    function automatic logic frame_bit(input logic [W-1:0] word, input int idx);
        if (idx < W) return word[idx];
        return ^word;
    endfunction

    task automatic test_reset();
        rst = 1'b0; load_valid = 1'b1; load_data = 8'hFF;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_checks++;
            if ({load_ready, out, out_valid, busy, last} !== 5'b0) begin
                n_fail++;
                $display("FAIL reset_hold cyc%0d: rdy/out/vld/busy/last=%b required 00000",
                         c, {load_ready, out, out_valid, busy, last});
            end
        end
        load_valid = 1'b0; rst = 1'b1;
        tick();
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || load_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: busy=%b out_valid=%b load_ready=%b required 0 0 1",
                     busy, out_valid, load_ready);
        end
    endtask

    task automatic test_single(input logic [W-1:0] word);
        load_valid = 1'b1; load_data = word;
        n_checks++;
        if (load_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ready: load_ready=%b required 1", load_ready);
        end
        tick();
        load_valid = 1'b0; load_data = ~word;
        for (int k = 0; k < FL; k++) begin
            n_checks++;
            if (out !== frame_bit(word, k) || out_valid !== 1'b1 || busy !== 1'b1 ||
                last !== (k == FL - 1)) begin
                n_fail++;
                $display("FAIL single_bit%0d word=%h: out=%b vld=%b busy=%b last=%b required %b 1 1 %b",
                         k, word, out, out_valid, busy, last, frame_bit(word, k), (k == FL - 1));
            end
            tick();
        end
        n_checks++;
        if (out !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || last !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle word=%h: out=%b vld=%b busy=%b last=%b required 0 0 0 0",
                     word, out, out_valid, busy, last);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] w0;
        logic [W-1:0] w1;
        logic         exp;
        w0 = 8'h0F; w1 = 8'hF0;
        load_valid = 1'b1; load_data = w0;
        tick();
        load_data = w1;
        for (int k = 0; k < 2 * FL; k++) begin
            exp = (k < FL) ? frame_bit(w0, k) : frame_bit(w1, k - FL);
            n_checks++;
            if (out !== exp || out_valid !== 1'b1 || busy !== 1'b1 ||
                last !== ((k % FL) == FL - 1)) begin
                n_fail++;
                $display("FAIL b2b_bit%0d: out=%b vld=%b busy=%b last=%b required %b 1 1 %b",
                         k, out, out_valid, busy, last, exp, ((k % FL) == FL - 1));
            end
            if (k == FL - 1) begin
                n_checks++;
                if (load_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_early_ready: load_ready=%b required 1", load_ready);
                end
            end
            tick();
            if (k == FL - 1) load_valid = 1'b0;
        end
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: out_valid=%b busy=%b required 0 0", out_valid, busy);
        end
    endtask

    task automatic test_reset_mid();
        load_valid = 1'b1; load_data = 8'hFF;
        tick();
        load_valid = 1'b0;
        tick();
        tick();
        n_checks++;
        if (out !== 1'b1 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_bit2: out=%b vld=%b required 1 1", out, out_valid);
        end
        rst = 1'b0; load_valid = 1'b1; load_data = 8'h55;
        #1;
        n_checks++;
        if (load_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_ready: load_ready=%b required 0", load_ready);
        end
        tick();
        n_checks++;
        if (out !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || last !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_abort: out=%b vld=%b busy=%b last=%b required 0 0 0 0",
                     out, out_valid, busy, last);
        end
        rst = 1'b1; load_valid = 1'b0;
        tick();
        test_single(8'h3C);
    endtask

    task automatic test_data_change();
        logic [W-1:0] w0;
        logic [W-1:0] w1;
        logic         exp;
        w0 = 8'h81; w1 = 8'h7E;
        load_valid = 1'b1; load_data = w0;
        tick();
        for (int k = 0; k < 2 * FL; k++) begin
            if (k == 2) load_data = w1;
            #1;
            exp = (k < FL) ? frame_bit(w0, k) : frame_bit(w1, k - FL);
            n_checks++;
            if (out !== exp || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL chg_bit%0d: out=%b vld=%b required %b 1", k, out, out_valid, exp);
            end
            if (k < FL) begin
                n_checks++;
                if (load_ready !== (k == FL - 1)) begin
                    n_fail++;
                    $display("FAIL chg_ready%0d: load_ready=%b required %b",
                             k, load_ready, (k == FL - 1));
                end
            end
            tick();
            if (k == FL - 1) load_valid = 1'b0;
        end
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL chg_idle: out_valid=%b busy=%b required 0 0", out_valid, busy);
        end
    endtask

    task automatic test_frame_length();
        int n_valid;
        int n_last;
        n_valid = 0; n_last = 0;
        load_valid = 1'b1; load_data = 8'h07;
        tick();
        load_valid = 1'b0;
        for (int c = 0; c < W + 4; c++) begin
            if (out_valid === 1'b1) begin
                n_checks++;
                if (out !== frame_bit(8'h07, n_valid)) begin
                    n_fail++;
                    $display("FAIL len_bit%0d: out=%b required %b",
                             n_valid, out, frame_bit(8'h07, n_valid));
                end
                n_valid++;
            end
            if (last === 1'b1) n_last = n_valid;
            tick();
        end
        n_checks++;
        if (n_valid != FL || n_last != FL) begin
            n_fail++;
            $display("FAIL frame_len: bits=%0d last_at=%0d required %0d %0d",
                     n_valid, n_last, FL, FL);
        end
    endtask

    initial begin
        rst = 1'b0; load_valid = 1'b0; load_data = '0;
        test_reset();
        test_single(8'hA5);
        test_back_to_back();
        test_reset_mid();
        test_data_change();
        test_frame_length();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
